crc5_stream_engine: RTL and testbench
=====================================

Name: crc5_stream_engine

Overview:
- Multi-channel, frame-aware CRC-5 generator/checker for the RCD bus datapath.
- Accumulates the CRC over multi-beat frames, one independent accumulator per channel, with sof/eof delimiting.
- Produces one registered result per frame through a valid/ready handshake.
- Checks each result against an expected CRC and keeps saturating mismatch and protocol-error counters.

Parameters:
- DWIDTH, 8, data bits per beat (1..64); processed MSB-first.
- NUM_CH, 4, independent channel accumulators (1..16).
- CRC_POLY, 5'h05, polynomial taps for x^5+x^2+1 (x^5 implicit).
- CRC_INIT, 5'h1F, accumulator value loaded at sof.
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_ch  in  $clog2(NUM_CH) (min 1)  channel id of the beat
- in_sof  in  1  first beat of frame
- in_eof  in  1  last beat of frame (sof && eof = single-beat frame)
- in_data  in  DWIDTH  beat payload
- in_crc_exp  in  5  expected CRC; sampled on eof beat only
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_ch  out  $clog2(NUM_CH)  channel of result
- res_crc  out  5  computed frame CRC
- res_match  out  1  res_crc == sampled in_crc_exp
- cnt_clr  in  1  synchronous clear of both counters
- crc_err_cnt  out  CNT_W  saturating count of mismatched frames
- proto_err_cnt  out  CNT_W  saturating count of protocol errors

Behaviour:
- Per-bit step, MSB of in_data first: fb = bit ^ crc[4]; crc = {crc[3:0],1'b0} ^ (fb ? CRC_POLY : 0). No final XOR, no reflection.
- Beat CRC is DWIDTH chained steps in one combinational cycle. Seed is CRC_INIT on a sof beat, otherwise the channel accumulator.
- Per-channel state is IDLE or IN_FRAME, plus a 5-bit accumulator.
  - Accepted sof && !eof: accumulator <= beat CRC; state -> IN_FRAME.
  - Accepted !sof && !eof in IN_FRAME: accumulator <= beat CRC.
  - Accepted eof with sof, or in IN_FRAME: result loaded; state -> IDLE.
  - Accepted sof on a channel already IN_FRAME: restart from CRC_INIT, old partial discarded, proto_err_cnt +1.
  - Accepted beat with !sof on an IDLE channel: dropped (no state change, no result), proto_err_cnt +1.
- Result register is a single entry.
  - Eof beat accepted in cycle N -> res_valid=1 in cycle N+1 with res_ch/res_crc/res_match. All fields are held stable until consumed.
  - in_ready = !res_valid || res_ready, one global ready for all beats. Full throughput of one frame per cycle when res_ready is held at 1.
  - Consume and new eof in the same cycle: the new result replaces the old one; res_valid stays 1.
- crc_err_cnt increments in the cycle the result loads with match=0.
- Both counters saturate at all-ones.
- cnt_clr wins over a same-cycle increment: the counter is 0 next cycle and that event is lost.
- Non-accepted beats (in_valid && !in_ready) have no effect on any state or counter.
- Reset values: res_valid=0, res_ch=0, res_crc=0, res_match=0, both counters=0, all channels IDLE, accumulators=CRC_INIT. in_ready=1 after reset.
- Reset mid-frame aborts all frames. A subsequent non-sof beat counts as a protocol error.
- in_ch >= NUM_CH (non-power-of-2 NUM_CH): beat dropped, proto_err_cnt +1.

Test Plan:
- DWIDTH=8, ch0 single beat sof=eof=1, data 8'h00, crc_exp 5'h0F -> next cycle res_valid=1, res_ch=0, res_crc=5'h0F, res_match=1, crc_err_cnt=0.
- ch1 two beats 8'h00 (sof, then eof), crc_exp 5'h01 -> res_crc=5'h01, match=1. Repeat with crc_exp 5'h02 -> match=0, crc_err_cnt=1.
- Interleave ch2 beats 8'h00/8'h00 with a ch3 single-beat 8'h00 between them -> ch3 result 5'h0F first, then ch2 result 5'h01; accumulators stay independent.
- Hold res_ready=0 after one result, then present another eof -> in_ready=0, beat not accepted, first result stable. Raise res_ready -> beat accepted, second result next cycle.
- Non-sof beat on IDLE ch0 -> proto_err_cnt=1, no result. Sof twice on ch1 -> proto_err_cnt=2. Force the count to all-ones and add one more error -> stays all-ones. Pulse cnt_clr -> 0.
- Assert rst_n low mid-frame on ch0 -> all outputs at reset values. Eof-only beat on ch0 afterwards -> no result, proto_err_cnt=1.

Source files
------------

// File: rtl/crc5_stream_engine.sv
// Multi-channel, frame-aware CRC-5 (x^5+x^2+1) generator/checker with a
// single-entry registered result and saturating mismatch/protocol counters.
module crc5_stream_engine #(
  parameter int          DWIDTH   = 8,
  parameter int          NUM_CH   = 4,
  parameter logic [4:0]  CRC_POLY = 5'h05,
  parameter logic [4:0]  CRC_INIT = 5'h1F,
  parameter int          CNT_W    = 16,
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [4:0]        in_crc_exp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [4:0]        res_crc,
  output logic              res_match,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  crc_err_cnt,
  output logic [CNT_W-1:0]  proto_err_cnt
);

  typedef enum logic {IDLE, IN_FRAME} ch_state_t;

  ch_state_t  st_q  [NUM_CH];
  ch_state_t  st_d  [NUM_CH];
  logic [4:0] acc_q [NUM_CH];
  logic [4:0] acc_d [NUM_CH];

  logic       accept;
  logic       ch_ok;
  logic       cur_in_frame;
  logic [4:0] seed;
  logic [4:0] beat_crc;
  logic       load;
  logic       match;
  logic       proto_inc;
  logic       crc_inc;

  // MSB-first serial LFSR unrolled over the whole beat.
  function automatic logic [4:0] crc_beat(input logic [4:0] s, input logic [DWIDTH-1:0] d);
    logic [4:0] c;
    logic       fb;
    c = s;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'h00);
    end
    return c;
  endfunction

  assign in_ready = !res_valid || res_ready;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = int'(in_ch) < NUM_CH;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    st_d         = st_q;
    acc_d        = acc_q;
    load         = 1'b0;
    proto_inc    = 1'b0;
    cur_in_frame = 1'b0;
    seed         = CRC_INIT;
    if (ch_ok) begin
      cur_in_frame = (st_q[in_ch] == IN_FRAME);
      seed         = in_sof ? CRC_INIT : acc_q[in_ch];
    end
    beat_crc = crc_beat(seed, in_data);
    match    = (beat_crc == in_crc_exp);

    if (accept) begin
      if (!ch_ok || (!in_sof && !cur_in_frame)) begin
        proto_inc = 1'b1;
      end else begin
        // A sof on an open frame discards the partial and restarts.
        if (in_sof && cur_in_frame) proto_inc = 1'b1;
        if (in_eof) begin
          load         = 1'b1;
          st_d[in_ch]  = IDLE;
        end else begin
          acc_d[in_ch] = beat_crc;
          st_d[in_ch]  = IN_FRAME;
        end
      end
    end
    crc_inc = load && !match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is small and must read CRC_INIT after reset, so it is reset explicitly rather than left to sof.
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= IDLE;
        acc_q[i] <= CRC_INIT;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      st_q  <= st_d;
      acc_q <= acc_d;
    end
  end

  // Result fields only change on load, so they stay stable while res_valid waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_crc   <= '0;
      res_match <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_ch    <= in_ch;
      res_crc   <= beat_crc;
      res_match <= match;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Clear takes priority; increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_cnt   <= '0;
      proto_err_cnt <= '0;
    end else if (cnt_clr) begin
      crc_err_cnt   <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (crc_inc && (crc_err_cnt != {CNT_W{1'b1}}))
        crc_err_cnt <= crc_err_cnt + CNT_W'(1);
      if (proto_inc && (proto_err_cnt != {CNT_W{1'b1}}))
        proto_err_cnt <= proto_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_crc5_stream_engine.sv
// Directed, table-driven bench for crc5_stream_engine with hand-computed CRCs
// plus sequences for backpressure, counter saturation/clear and mid-frame reset.
module tb_crc5_stream_engine;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic       in_sof;
  logic       in_eof;
  logic [7:0] in_data;
  logic [4:0] in_crc_exp;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_ch;
  logic [4:0] res_crc;
  logic       res_match;
  logic       cnt_clr;
  logic [CNT_W-1:0] crc_err_cnt;
  logic [CNT_W-1:0] proto_err_cnt;

  int checks = 0;
  int errors = 0;

  crc5_stream_engine #(.DWIDTH(8), .NUM_CH(4), .CRC_POLY(5'h05), .CRC_INIT(5'h1F), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_sof(in_sof),
    .in_eof(in_eof), .in_data(in_data), .in_crc_exp(in_crc_exp),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_crc(res_crc),
    .res_match(res_match), .cnt_clr(cnt_clr),
    .crc_err_cnt(crc_err_cnt), .proto_err_cnt(proto_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic       sof;
    logic       eof;
    logic [7:0] data;
    logic [4:0] exp;
    logic       rv;
    logic [1:0] rch;
    logic [4:0] rcrc;
    logic       rm;
    int         ce;
    int         pe;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [1:0] ch, input logic sof, input logic eof,
                              input logic [7:0] data, input logic [4:0] exp,
                              input logic rv, input logic [1:0] rch, input logic [4:0] rcrc,
                              input logic rm, input int ce, input int pe);
    vec_t v;
    v.ch = ch; v.sof = sof; v.eof = eof; v.data = data; v.exp = exp;
    v.rv = rv; v.rch = rch; v.rcrc = rcrc; v.rm = rm; v.ce = ce; v.pe = pe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_beat(input logic [1:0] ch, input logic sof, input logic eof,
                          input logic [7:0] data, input logic [4:0] exp);
    in_valid = 1'b1; in_ch = ch; in_sof = sof; in_eof = eof; in_data = data; in_crc_exp = exp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] ch, input logic sof, input logic eof,
                      input logic [7:0] data, input logic [4:0] exp);
    set_beat(ch, sof, eof, data, exp);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // CRC values below are worked by hand from seed 5'h1F:
    // 00 -> 0F, 00 00 -> 01, 00 00 00 -> 0D, FF -> 1B, 80 -> 01.
    vecs[0]  = mk(2'd0, 1, 1, 8'h00, 5'h0F, 1, 2'd0, 5'h0F, 1, 0, 0);
    vecs[1]  = mk(2'd1, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 0, 0);
    vecs[2]  = mk(2'd1, 0, 1, 8'h00, 5'h01, 1, 2'd1, 5'h01, 1, 0, 0);
    vecs[3]  = mk(2'd1, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 0, 0);
    vecs[4]  = mk(2'd1, 0, 1, 8'h00, 5'h02, 1, 2'd1, 5'h01, 0, 1, 0);
    vecs[5]  = mk(2'd2, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 1, 0);
    vecs[6]  = mk(2'd3, 1, 1, 8'h00, 5'h0F, 1, 2'd3, 5'h0F, 1, 1, 0);
    vecs[7]  = mk(2'd2, 0, 1, 8'h00, 5'h01, 1, 2'd2, 5'h01, 1, 1, 0);
    vecs[8]  = mk(2'd0, 0, 1, 8'h00, 5'h0F, 0, 2'd0, 5'h00, 0, 1, 1);
    vecs[9]  = mk(2'd1, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 1, 1);
    vecs[10] = mk(2'd1, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 1, 2);
    vecs[11] = mk(2'd1, 0, 1, 8'h00, 5'h01, 1, 2'd1, 5'h01, 1, 1, 2);
    vecs[12] = mk(2'd0, 1, 1, 8'hFF, 5'h1B, 1, 2'd0, 5'h1B, 1, 1, 2);
    vecs[13] = mk(2'd3, 1, 1, 8'h80, 5'h00, 1, 2'd3, 5'h01, 0, 2, 2);
    vecs[14] = mk(2'd2, 1, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 2, 2);
    vecs[15] = mk(2'd2, 0, 0, 8'h00, 5'h00, 0, 2'd0, 5'h00, 0, 2, 2);
    vecs[16] = mk(2'd2, 0, 1, 8'h00, 5'h0D, 1, 2'd2, 5'h0D, 1, 2, 2);

    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_sof = 0; in_eof = 0;
    in_data = '0; in_crc_exp = '0; res_ready = 1'b1; cnt_clr = 1'b0;
    #23;
    check("reset res_valid", res_valid, 0);
    check("reset res_ch", res_ch, 0);
    check("reset res_crc", res_crc, 0);
    check("reset res_match", res_match, 0);
    check("reset crc_err_cnt", crc_err_cnt, 0);
    check("reset proto_err_cnt", proto_err_cnt, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      beat(vecs[i].ch, vecs[i].sof, vecs[i].eof, vecs[i].data, vecs[i].exp);
      check($sformatf("v%0d res_valid", i), res_valid, vecs[i].rv);
      if (vecs[i].rv) begin
        check($sformatf("v%0d res_ch", i), res_ch, vecs[i].rch);
        check($sformatf("v%0d res_crc", i), res_crc, vecs[i].rcrc);
        check($sformatf("v%0d res_match", i), res_match, vecs[i].rm);
      end
      check($sformatf("v%0d crc_err_cnt", i), crc_err_cnt, vecs[i].ce);
      check($sformatf("v%0d proto_err_cnt", i), proto_err_cnt, vecs[i].pe);
    end
    tick();
    check("drain res_valid", res_valid, 0);

    // Backpressure: first result held while the next eof is stalled.
    res_ready = 1'b0;
    beat(2'd0, 1, 1, 8'h00, 5'h0F);
    check("bp first res_valid", res_valid, 1);
    set_beat(2'd1, 1, 1, 8'hFF, 5'h00);
    #1;
    check("bp in_ready low", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp hold res_ch", res_ch, 0);
      check("bp hold res_crc", res_crc, 5'h0F);
      check("bp hold res_match", res_match, 1);
      check("bp hold crc_err_cnt", crc_err_cnt, 2);
    end
    res_ready = 1'b1;
    #1;
    check("bp in_ready high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp second res_valid", res_valid, 1);
    check("bp second res_ch", res_ch, 1);
    check("bp second res_crc", res_crc, 5'h1B);
    check("bp second res_match", res_match, 0);
    check("bp second crc_err_cnt", crc_err_cnt, 3);
    tick();
    check("bp consumed res_valid", res_valid, 0);

    // Saturation of both counters, then clear.
    for (int k = 0; k < 20; k++) beat(2'd0, 0, 0, 8'h00, 5'h00);
    check("sat proto_err_cnt", proto_err_cnt, 4'hF);
    for (int k = 0; k < 20; k++) beat(2'd3, 1, 1, 8'h00, 5'h00);
    check("sat crc_err_cnt", crc_err_cnt, 4'hF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr crc_err_cnt", crc_err_cnt, 0);
    check("clr proto_err_cnt", proto_err_cnt, 0);
    cnt_clr = 1'b1;
    beat(2'd0, 0, 1, 8'h00, 5'h00);
    cnt_clr = 1'b0;
    check("clr wins proto_err_cnt", proto_err_cnt, 0);
    check("clr wins res_valid", res_valid, 0);

    // Reset in the middle of a ch0 frame.
    beat(2'd0, 1, 0, 8'h00, 5'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst res_valid", res_valid, 0);
    check("rst res_crc", res_crc, 0);
    check("rst res_ch", res_ch, 0);
    check("rst in_ready", in_ready, 1);
    check("rst proto_err_cnt", proto_err_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(2'd0, 0, 1, 8'h00, 5'h01);
    check("post-rst res_valid", res_valid, 0);
    check("post-rst proto_err_cnt", proto_err_cnt, 1);
    beat(2'd0, 1, 1, 8'h00, 5'h0F);
    check("post-rst single res_crc", res_crc, 5'h0F);
    check("post-rst single res_match", res_match, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
